// File: rtl/uart_tx_arbiter_if.sv
// Producer-side handshake and physical_uart signals shared by uart_tx_arbiter and its environment.
// master = arbiter side, slave = producers plus transmitter side.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 4
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_ready;
    logic [7:0]           uart_byte_tx;
    logic                 uart_start_tx;
    logic                 uart_done_tx;
    logic                 busy;
    logic [ID_W-1:0]      grant_id;
    logic                 timeout_err;
    logic                 err_clr;

    modport master (
        input  req_valid, req_data, uart_done_tx, err_clr,
        output req_ready, uart_byte_tx, uart_start_tx, busy, grant_id, timeout_err
    );

    modport slave (
        output req_valid, req_data, uart_done_tx, err_clr,
        input  req_ready, uart_byte_tx, uart_start_tx, busy, grant_id, timeout_err
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin share of one physical_uart transmitter among NUM_REQ byte producers; option UART_ID_HEADER_EN adds an id header byte.
// Latency: accept to uart_start_tx 1 cycle; next accept 1 cycle after the uart_done_tx rising edge.
// Backpressure: req_ready pulses only in IDLE, so producers hold req_valid/req_data until accepted.
module uart_tx_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int ID_W           = 4,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic              clk,
    input  logic              arstn,
    uart_tx_arbiter_if.master bus
);
    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(NUM_REQ - 1);

`ifdef UART_ID_HEADER_EN
    typedef enum logic [2:0] {IDLE, HDR_START, HDR_WAIT, START, WAIT} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, WAIT} state_t;
`endif

    state_t              state;
    state_t              state_nxt;
    logic [PTR_W-1:0]    rr_ptr;
    logic [PTR_W-1:0]    cand;
    logic [PTR_W-1:0]    winner;
    logic                found;
    logic                accept;
    logic [7:0]          win_dat;
    logic [7:0]          hold_q;
    logic [ID_W-1:0]     grant_q;
    logic [CNT_W-1:0]    wd_cnt;
    logic                wd_clr;
    logic                in_wait;
    logic                timeout;
    logic                done_q;
    logic                done_rise;
    logic                err_q;
    logic [NUM_REQ-1:0]  ready_vec;
`ifdef UART_ID_HEADER_EN
    logic [7:0]          byte_q;
    logic [7:0]          byte_nxt;
`endif

    // First valid requester at or above rr_ptr, wrapping past NUM_REQ-1.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = PTR_W'((int'(rr_ptr) + k) % NUM_REQ);
            if (!found && bus.req_valid[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    // Reset also masks the combinational accept so req_ready reads 0 during reset.
    assign accept    = found && (state == IDLE) && !arstn;
    assign win_dat   = 8'(bus.req_data >> (8 * int'(winner)));
    assign ready_vec = accept ? (NUM_REQ'(1) << winner) : '0;
    assign done_rise = bus.uart_done_tx && !done_q;

`ifdef UART_ID_HEADER_EN
    assign in_wait = (state == WAIT) || (state == HDR_WAIT);
`else
    assign in_wait = (state == WAIT);
`endif

    always_ff @(posedge clk or posedge arstn) begin
        if (arstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        wd_clr    = 1'b0;
        timeout   = 1'b0;
`ifdef UART_ID_HEADER_EN
        byte_nxt  = byte_q;
`endif
        case (state)
            IDLE: begin
                if (accept) begin
`ifdef UART_ID_HEADER_EN
                    state_nxt = HDR_START;
                    byte_nxt  = {4'hA, 4'(winner)};
`else
                    state_nxt = START;
`endif
                end
            end
`ifdef UART_ID_HEADER_EN
            HDR_START: begin
                wd_clr    = 1'b1;
                state_nxt = HDR_WAIT;
            end
            HDR_WAIT: begin
                if (done_rise) begin
                    state_nxt = START;
                    byte_nxt  = hold_q;
                end else if (wd_cnt == CNT_LAST) begin
                    // A dead header frame drops the data byte with it.
                    timeout   = 1'b1;
                    state_nxt = IDLE;
                end
            end
`endif
            START: begin
                wd_clr    = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: begin
                if (done_rise) begin
                    state_nxt = IDLE;
                end else if (wd_cnt == CNT_LAST) begin
                    timeout   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge arstn) begin
        if (arstn) begin
            rr_ptr  <= '0;
            hold_q  <= '0;
            grant_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            wd_cnt  <= '0;
        end else begin
            done_q <= bus.uart_done_tx;
            if (accept) begin
                hold_q  <= win_dat;
                grant_q <= ID_W'(winner);
                rr_ptr  <= (winner == PTR_LAST) ? '0 : winner + 1'b1;
            end
            if (bus.err_clr) begin
                err_q <= 1'b0;
            end else if (timeout) begin
                err_q <= 1'b1;
            end
            // Saturating watchdog; the FSM leaves WAIT before it would ever hold.
            if (wd_clr) begin
                wd_cnt <= '0;
            end else if (in_wait && (wd_cnt != CNT_LAST)) begin
                wd_cnt <= wd_cnt + 1'b1;
            end
        end
    end

`ifdef UART_ID_HEADER_EN
    always_ff @(posedge clk or posedge arstn) begin
        if (arstn) begin
            byte_q <= '0;
        end else begin
            byte_q <= byte_nxt;
        end
    end

    assign bus.uart_byte_tx  = byte_q;
    assign bus.uart_start_tx = (state == START) || (state == HDR_START);
`else
    // hold_q is loaded at accept, so it first changes on the START cycle.
    assign bus.uart_byte_tx  = hold_q;
    assign bus.uart_start_tx = (state == START);
`endif

    assign bus.req_ready   = ready_vec;
    assign bus.busy        = (state != IDLE);
    assign bus.grant_id    = grant_q;
    assign bus.timeout_err = err_q;

endmodule
